prog_loader: RTL and testbench

//  Writer-side counterpart of the instruction decoder. Accepts a stream of {opcode, immediate} beats over valid/ready.

---
 rtl/prog_loader.sv | 160 ++++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program loader: validates {op,imm} beats and writes program RAM; optional LOADER_CHECKSUM_EN trailer check
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_op,
    input  logic [7:0]        in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_count;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [15:0]         r_mem_wdata;
    logic [1:0]          r_err_code;
    logic                w_accept;
    logic                w_full;
    logic                w_legal;
    logic                w_write;
    logic                w_err_set;
    logic [1:0]          w_err_val;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          r_sum;
`endif

    // MY8CPU opcode map; everything outside this set is rejected
    function automatic logic f_legal(input logic [7:0] op);
        return op inside {[8'h00:8'h15], 8'h18, 8'h19, 8'h1C, 8'h1D,
                          [8'h20:8'h29], [8'h2C:8'h2E],
                          8'h30, 8'h34, 8'h38, 8'h3C};
    endfunction

    assign in_ready = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_full   = (r_count == DEPTH_C);
    assign w_legal  = f_legal(in_op);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state, write and error decisions; start overrides every state
    always_comb begin
        w_next    = r_state;
        w_write   = 1'b0;
        w_err_set = 1'b0;
        w_err_val = 2'd0;
        if (start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_full) begin
                            w_next    = S_ERR;
                            w_err_set = 1'b1;
                            w_err_val = 2'd2;
                        end else if (!w_legal) begin
                            w_next    = S_ERR;
                            w_err_set = 1'b1;
                            w_err_val = 2'd1;
                        end else begin
                            w_write = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            if (in_last) w_next = S_CHECK;
`else
                            if (in_last) w_next = S_DONE;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    // Trailer beat: only the immediate carries the checksum
                    if (w_accept) begin
                        if (in_imm == r_sum) begin
                            w_next = S_DONE;
                        end else begin
                            w_next    = S_ERR;
                            w_err_set = 1'b1;
                            w_err_val = 2'd3;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Write port, word counter and error code; counter never passes DEPTH since overflow beats are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_count     <= '0;
            r_err_code  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_mem_we <= w_write;
            if (start) begin
                r_count    <= '0;
                r_err_code <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                r_sum      <= 8'd0;
`endif
            end else begin
                if (w_write) begin
                    r_mem_addr  <= r_count[ADDR_W-1:0];
                    r_mem_wdata <= {in_op, in_imm};
                    r_count     <= r_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_sum       <= r_sum + in_op + in_imm;
`endif
                end
                if (w_err_set) r_err_code <= w_err_val;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_count;
    assign err_code   = r_err_code;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign cpu_hold   = (r_state != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader (DEPTH=4), checksum case under LOADER_CHECKSUM_EN
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [7:0]  in_imm;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    prog_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        wa.delete();
        wd.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] op, input logic [7:0] imm, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_imm   = imm;
        in_last  = last;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_op    = 8'h00;
        in_imm   = 8'h00;
    endtask

    task automatic trailer(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
        beat(8'h00, s, 1'b0);
        idle();
`endif
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold", cpu_hold, 1);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_flags", {done, error, err_code}, 0);
        check_eq("rst_count", word_count, 0);
        check_eq("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic load
        do_start();
        beat(8'h22, 8'h05, 1'b0);
        beat(8'h00, 8'h00, 1'b0);
        beat(8'h34, 8'h00, 1'b1);
        idle();
        trailer(8'h5B);
        settle();
        check_eq("t1_nwr", wa.size(), 3);
        check_eq("t1_w0", {wa[0], wd[0]}, 24'h00_2205);
        check_eq("t1_w1", {wa[1], wd[1]}, 24'h01_0000);
        check_eq("t1_w2", {wa[2], wd[2]}, 24'h02_3400);
        check_eq("t1_done", done, 1);
        check_eq("t1_hold", cpu_hold, 0);
        check_eq("t1_count", word_count, 3);
        check_eq("t1_err", error, 0);
        check_eq("t1_ready", in_ready, 0);

        // 2: illegal opcode
        do_start();
        check_eq("t2_clr", {done, error, cpu_hold}, 3'b001);
        beat(8'h02, 8'h01, 1'b0);
        beat(8'h16, 8'h00, 1'b0);
        idle();
        settle();
        check_eq("t2_nwr", wa.size(), 1);
        check_eq("t2_w0", {wa[0], wd[0]}, 24'h00_0201);
        check_eq("t2_err", error, 1);
        check_eq("t2_code", err_code, 1);
        check_eq("t2_hold", cpu_hold, 1);
        check_eq("t2_count", word_count, 1);

        // 3a: overflow on 5th beat
        do_start();
        check_eq("t3_codeclr", err_code, 0);
        for (int i = 0; i < 5; i++) beat(8'h00, 8'(i), (i == 4));
        idle();
        settle();
        check_eq("t3a_nwr", wa.size(), 4);
        check_eq("t3a_w3", {wa[3], wd[3]}, 24'h03_0003);
        check_eq("t3a_err", error, 1);
        check_eq("t3a_code", err_code, 2);
        check_eq("t3a_count", word_count, 4);

        // 3b: last beat exactly fills memory
        do_start();
        for (int i = 0; i < 4; i++) beat(8'h00, 8'(i), (i == 3));
        idle();
        trailer(8'h06);
        settle();
        check_eq("t3b_nwr", wa.size(), 4);
        check_eq("t3b_done", done, 1);
        check_eq("t3b_count", word_count, 4);
        check_eq("t3b_err", error, 0);

        // 4: back-to-back beats, then start with a beat present
        do_start();
        beat(8'h20, 8'h01, 1'b0);
        check_eq("t4_c0", {mem_we, mem_addr, mem_wdata}, 25'h1_00_2001);
        beat(8'h21, 8'h02, 1'b0);
        check_eq("t4_c1", {mem_we, mem_addr, mem_wdata}, 25'h1_01_2102);
        beat(8'h29, 8'h03, 1'b0);
        check_eq("t4_c2", {mem_we, mem_addr, mem_wdata}, 25'h1_02_2903);
        idle();
        @(posedge clk); #1;
        check_eq("t4_gap", {mem_we, mem_addr, mem_wdata}, 25'h0_02_2903);
        start    = 1'b1;
        in_valid = 1'b1;
        in_op    = 8'h20;
        in_imm   = 8'hAA;
        #1;
        check_eq("t4_rdy_start", in_ready, 0);
        @(posedge clk); #1;
        start  = 1'b0;
        check_eq("t4_nowr", mem_we, 0);
        check_eq("t4_cnt0", word_count, 0);
        in_op  = 8'h21;
        in_imm = 8'hBB;
        @(posedge clk); #1;
        check_eq("t4_after", {mem_we, mem_addr, mem_wdata}, 25'h1_00_21BB);
        idle();
        @(posedge clk); #1;

        // 5: async reset mid-load
        do_start();
        beat(8'h30, 8'h11, 1'b0);
        beat(8'h38, 8'h22, 1'b0);
        idle();
        @(posedge clk); #1;
        check_eq("t5_pre", word_count, 2);
        rst_n = 1'b0;
        #1;
        check_eq("t5_count", word_count, 0);
        check_eq("t5_hold", cpu_hold, 1);
        check_eq("t5_out", {mem_we, mem_addr, mem_wdata}, 25'h0);
        check_eq("t5_flags", {done, error, err_code, in_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_idle", {in_ready, cpu_hold}, 2'b01);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        do_start();
        beat(8'h02, 8'h10, 1'b0);
        beat(8'h34, 8'h00, 1'b1);
        idle();
        @(posedge clk); #1;
        check_eq("t6_check", {done, error, in_ready}, 3'b001);
        trailer(8'h46);
        settle();
        check_eq("t6_done", done, 1);
        check_eq("t6_nwr", wa.size(), 2);
        do_start();
        beat(8'h02, 8'h10, 1'b0);
        beat(8'h34, 8'h00, 1'b1);
        idle();
        trailer(8'h47);
        settle();
        check_eq("t6_err", error, 1);
        check_eq("t6_code", err_code, 3);
        check_eq("t6_nwr2", wa.size(), 2);
        check_eq("t6_count", word_count, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
